// File: rtl/bist_pkg.sv
// Shared definitions for the BIST session controller: FSM state encoding and
// default signature constants also used by the LFSR/MISR top level.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } bist_state_t;

    localparam int DEF_N_PATTERNS    = 7;
    localparam int DEF_RESEED_PERIOD = 4;
    localparam int DEF_SIG_W         = 3;
    localparam logic [DEF_SIG_W-1:0] DEF_GOLDEN_SIG = 3'b101;

    // True when the captured signature equals the expected fault-free value.
    function automatic logic sig_match(input logic [DEF_SIG_W-1:0] sig,
                                       input logic [DEF_SIG_W-1:0] golden);
        return (sig == golden);
    endfunction

endpackage

// File: rtl/bist_pat_counter.sv
// Pattern index counter with terminal-count flag, plus a modulo-RESEED_PERIOD
// sub-counter. reseed_next looks ahead one cycle so the controller can register
// LfsrSeed in step with the pattern index it belongs to.
module bist_pat_counter
    import bist_pkg::*;
#(
    parameter int N_PATTERNS    = DEF_N_PATTERNS,
    parameter int RESEED_PERIOD = DEF_RESEED_PERIOD,
    parameter int CNT_W         = $clog2(N_PATTERNS + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc,
    output logic             reseed_next
);

    localparam int MOD_W = (RESEED_PERIOD > 1) ? $clog2(RESEED_PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PATTERNS - 1);
    localparam logic [MOD_W-1:0] LAST_MOD = (RESEED_PERIOD > 0) ? MOD_W'(RESEED_PERIOD - 1) : '0;
    localparam logic             RESEED_ON = (RESEED_PERIOD > 0) ? 1'b1 : 1'b0;

    logic [MOD_W-1:0] mod_r;
    logic [MOD_W-1:0] mod_next_s;
    logic             step_s;

    assign tc          = (count == LAST_CNT);
    assign step_s      = en & ~tc;
    assign reseed_next = RESEED_ON & (mod_next_s == LAST_MOD);

    // Next value of the reseed sub-counter; wraps at RESEED_PERIOD-1.
    always_comb begin
        mod_next_s = mod_r;
        if (clr) begin
            mod_next_s = '0;
        end else if (step_s) begin
            if (mod_r == LAST_MOD) begin
                mod_next_s = '0;
            end else begin
                mod_next_s = mod_r + MOD_W'(1);
            end
        end else begin
            mod_next_s = mod_r;
        end
    end

    // Pattern index and reseed phase registers; the index saturates at N_PATTERNS-1.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            count <= '0;
            mod_r <= '0;
        end else begin
            mod_r <= mod_next_s;
            if (clr) begin
                count <= '0;
            end else if (step_s) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bist_controller.sv
// BIST session sequencer: INIT the LFSR and clear the MISR, apply N_PATTERNS
// patterns with periodic reseed pulses, flush the last CUT response, compare
// the signature and report Done/Pass. All outputs are registered.
module bist_controller
    import bist_pkg::*;
#(
    parameter int N_PATTERNS    = DEF_N_PATTERNS,
    parameter int RESEED_PERIOD = DEF_RESEED_PERIOD,
    parameter int SIG_W         = DEF_SIG_W,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = SIG_W'(DEF_GOLDEN_SIG),
    parameter int CNT_W         = $clog2(N_PATTERNS + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Abort,
    input  logic [SIG_W-1:0] Sig,
    output logic             LfsrInit,
    output logic             LfsrSeed,
    output logic             TestMode,
    output logic             MisrEn,
    output logic             MisrClr,
    output logic             Busy,
    output logic             Done,
    output logic             Pass,
    output logic [CNT_W-1:0] PatCnt
);

    bist_state_t state_r;
    logic        cnt_clr_s;
    logic        cnt_en_s;
    logic        cnt_tc_s;
    logic        reseed_next_s;

    bist_pat_counter #(
        .N_PATTERNS    (N_PATTERNS),
        .RESEED_PERIOD (RESEED_PERIOD),
        .CNT_W         (CNT_W)
    ) u_pat_counter (
        .CLK         (CLK),
        .RST         (RST),
        .clr         (cnt_clr_s),
        .en          (cnt_en_s),
        .count       (PatCnt),
        .tc          (cnt_tc_s),
        .reseed_next (reseed_next_s)
    );

    // Counter control: zero whenever the session heads to IDLE/INIT, advance in RUN.
    always_comb begin
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_clr_s = 1'b1;
            end
            INIT: begin
                cnt_clr_s = 1'b1;
            end
            RUN: begin
                if (Abort) begin
                    cnt_clr_s = 1'b1;
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            FLUSH, CHECK: begin
                if (Abort) begin
                    cnt_clr_s = 1'b1;
                end else begin
                    cnt_clr_s = 1'b0;
                end
            end
            DONE: begin
                if (!Start) begin
                    cnt_clr_s = 1'b1;
                end else begin
                    cnt_clr_s = 1'b0;
                end
            end
            default: begin
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // Session FSM; each output register is loaded with the value of the state being entered.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r  <= IDLE;
            LfsrInit <= 1'b0;
            LfsrSeed <= 1'b1;
            TestMode <= 1'b0;
            MisrEn   <= 1'b0;
            MisrClr  <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Pass     <= 1'b0;
        end else begin
            LfsrInit <= 1'b0;
            LfsrSeed <= 1'b1;
            TestMode <= 1'b0;
            MisrEn   <= 1'b0;
            MisrClr  <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            case (state_r)
                IDLE: begin
                    Pass <= 1'b0;
                    if (Start) begin
                        state_r  <= INIT;
                        LfsrInit <= 1'b1;
                        MisrClr  <= 1'b1;
                        Busy     <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                INIT: begin
                    if (Abort) begin
                        state_r <= IDLE;
                        Pass    <= 1'b0;
                    end else begin
                        state_r  <= RUN;
                        TestMode <= 1'b1;
                        MisrEn   <= 1'b1;
                        Busy     <= 1'b1;
                        LfsrSeed <= ~reseed_next_s;
                    end
                end
                RUN: begin
                    if (Abort) begin
                        state_r <= IDLE;
                        Pass    <= 1'b0;
                    end else if (cnt_tc_s) begin
                        state_r  <= FLUSH;
                        TestMode <= 1'b1;
                        MisrEn   <= 1'b1;
                        Busy     <= 1'b1;
                    end else begin
                        state_r  <= RUN;
                        TestMode <= 1'b1;
                        MisrEn   <= 1'b1;
                        Busy     <= 1'b1;
                        LfsrSeed <= ~reseed_next_s;
                    end
                end
                FLUSH: begin
                    if (Abort) begin
                        state_r <= IDLE;
                        Pass    <= 1'b0;
                    end else begin
                        state_r <= CHECK;
                        Busy    <= 1'b1;
                    end
                end
                CHECK: begin
                    if (Abort) begin
                        state_r <= IDLE;
                        Pass    <= 1'b0;
                    end else begin
                        state_r <= DONE;
                        Done    <= 1'b1;
                        Pass    <= sig_match(DEF_SIG_W'(Sig), DEF_SIG_W'(GOLDEN_SIG));
                    end
                end
                DONE: begin
                    if (Start) begin
                        state_r <= DONE;
                        Done    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        Pass    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    Pass    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
- Sequences one built-in self-test session around the 3-bit Fibonacci LFSR pattern generator (polynomial 1+x^2+x^3).
- Initialises the LFSR, then runs a fixed number of patterns with periodic one-cycle switches to the alternate reseed feedback.
- Enables and clears the response compactor (MISR), compares the final signature against a golden value, and reports pass/fail.
- Sits between the test-access logic (Start/Abort) and the LFSR/MISR datapath.

Parameters:
- N_PATTERNS, 7, number of RUN cycles (patterns applied); must be >= 1.
- RESEED_PERIOD, 4, reseed pulse issued every RESEED_PERIOD patterns; 0 disables reseeding.
- SIG_W, 3, width of the MISR signature.
- GOLDEN_SIG, 3'b101, expected fault-free signature.
- CNT_W, $clog2(N_PATTERNS+1), pattern counter width.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-low.
- Start  in  1  level request to begin a session; sampled in IDLE and DONE.
- Abort  in  1  terminates a session in progress.
- Sig  in  SIG_W  MISR signature, sampled in CHECK.
- LfsrInit  out  1  drives the LFSR reset input; high loads the all-ones state.
- LfsrSeed  out  1  drives the LFSR Seed input; 1 = normal feedback, 0 = reseed feedback.
- TestMode  out  1  selects LFSR patterns onto the CUT inputs.
- MisrEn  out  1  MISR capture enable.
- MisrClr  out  1  MISR synchronous clear.
- Busy  out  1  session in progress.
- Done  out  1  session complete; Pass is valid.
- Pass  out  1  signature matched GOLDEN_SIG.
- PatCnt  out  CNT_W  index of the current pattern.

Behaviour:
- Reset (RST=0 at a clock edge):
  - State goes to IDLE.
  - LfsrInit=0, LfsrSeed=1, TestMode=0, MisrEn=0, MisrClr=0, Busy=0, Done=0, Pass=0, PatCnt=0.
  - Reset takes priority over everything, including mid-session.
- All outputs are registered (Moore).
- IDLE: all outputs at reset values. Start=1 -> INIT.
- INIT (1 cycle):
  - LfsrInit=1, MisrClr=1, Busy=1, PatCnt=0.
  - Next state RUN.
- RUN (N_PATTERNS cycles):
  - TestMode=1, MisrEn=1, Busy=1.
  - PatCnt increments each cycle, 0..N_PATTERNS-1.
  - LfsrSeed=0 for exactly the cycle where PatCnt mod RESEED_PERIOD == RESEED_PERIOD-1; otherwise 1.
  - Next state FLUSH when PatCnt==N_PATTERNS-1.
- FLUSH (1 cycle):
  - TestMode=1, MisrEn=1, LfsrSeed=1.
  - Captures the last CUT response (CUT has 1-cycle latency).
  - PatCnt holds at N_PATTERNS-1.
- CHECK (1 cycle):
  - TestMode=0, MisrEn=0.
  - Pass register is loaded with (Sig==GOLDEN_SIG).
- DONE:
  - Done=1, Busy=0; Pass is held.
  - Stays in DONE while Start=1, so there is no auto-restart.
  - Start=0 -> IDLE, which clears Done and Pass.
- Latency: Start first sampled high in IDLE -> Done=1 exactly N_PATTERNS+3 cycles later.
- Abort=1 in INIT, RUN, FLUSH or CHECK:
  - Next state IDLE with all outputs at reset values; Pass=0.
  - Abort is ignored in IDLE and DONE.
  - Abort and Start both high in IDLE: Start wins, because Abort is only evaluated outside IDLE.
- RESEED_PERIOD=0 or RESEED_PERIOD > N_PATTERNS: LfsrSeed never goes low.
- Counter never wraps; its terminal value is N_PATTERNS-1.

Decomposition:
- Shared package bist_pkg:
  - state enum: IDLE, INIT, RUN, FLUSH, CHECK, DONE;
  - default GOLDEN_SIG and SIG_W constants, shared with the MISR and LFSR top level.
- One sub-module, bist_pat_counter:
  - CNT_W counter with clear, enable and terminal-count flag;
  - modulo-RESEED_PERIOD sub-counter producing the reseed strobe.
- FSM and output registers live in bist_controller.

Test Plan:
- Defaults, Sig tied to 3'b101, Start pulsed high in IDLE -> LfsrInit high 1 cycle, RUN for 7 cycles (PatCnt 0..6), Done=1 and Pass=1 exactly 10 cycles after Start.
- Same run -> LfsrSeed=0 only in the cycle with PatCnt=3, 1 everywhere else; MisrClr high only in INIT; MisrEn high for 8 consecutive cycles.
- Sig=3'b100 at CHECK -> Done=1, Pass=0; then Start=0 -> IDLE with Done=0, Pass=0.
- Abort=1 when PatCnt=2 -> next cycle IDLE: TestMode=0, MisrEn=0, Busy=0, PatCnt=0; Done never asserts.
- RST=0 during FLUSH -> all outputs at reset values next edge; a new Start then gives a normal 10-cycle session.
- Start held high through DONE for 5 cycles -> remains in DONE, no second INIT; Start low for 1 cycle, then high -> new session begins.
